// File: rtl/tdm_sel_if.sv
// Request/dwell inputs and select/status outputs of the TDM select controller.
interface tdm_sel_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               en;
  logic               req_1;
  logic               req_2;
  logic [DWELL_W-1:0] dwell_1;
  logic [DWELL_W-1:0] dwell_2;
  logic               sel;
  logic               out_valid;
  logic               switch_pulse;
  logic               busy;

  modport master (
    output en, req_1, req_2, dwell_1, dwell_2,
    input  sel, out_valid, switch_pulse, busy
  );

  modport slave (
    input  en, req_1, req_2, dwell_1, dwell_2,
    output sel, out_valid, switch_pulse, busy
  );
endinterface

// File: rtl/tdm_sel_ctrl.sv
// Time-division controller driving the transmission-gate mux select: round-robin
// grant between two channels, settle gap after each grant, programmable dwell.
module tdm_sel_ctrl #(
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic      clk,
  input  logic      rst,
  tdm_sel_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  localparam logic [3:0]         SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
  localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1'b1);

  // A programmed dwell of zero still owns the output for one cycle.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    dwell_eff = (d == {DWELL_W{1'b0}}) ? DWELL_ONE : d;
  endfunction

  state_t             r_state;
  logic [3:0]         r_settle_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_last_served;
  logic               r_sel;
  logic               r_out_valid;
  logic               r_switch_pulse;
  logic               r_busy;

  logic               w_any_req;
  logic               w_pick;
  logic [DWELL_W-1:0] w_pick_dwell;
  logic               w_cur_req;
  logic               w_other_req;
  logic [DWELL_W-1:0] w_cur_dwell;
  logic [DWELL_W-1:0] w_other_dwell;

  // Channel pick and dwell lookups for the current and alternate channel.
  always_comb begin
    w_any_req = io_bus.req_1 | io_bus.req_2;
    w_pick    = 1'b0;
    if (io_bus.req_1 && io_bus.req_2) begin
      w_pick = ~r_last_served;
    end else if (io_bus.req_2) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
    w_pick_dwell  = dwell_eff(w_pick ? io_bus.dwell_2 : io_bus.dwell_1);
    w_cur_req     = r_sel ? io_bus.req_2 : io_bus.req_1;
    w_other_req   = r_sel ? io_bus.req_1 : io_bus.req_2;
    w_cur_dwell   = dwell_eff(r_sel ? io_bus.dwell_2 : io_bus.dwell_1);
    w_other_dwell = dwell_eff(r_sel ? io_bus.dwell_1 : io_bus.dwell_2);
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_settle_cnt   <= 4'd0;
      r_dwell_cnt    <= {DWELL_W{1'b0}};
      r_last_served  <= 1'b1;
      r_sel          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_switch_pulse <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_switch_pulse <= 1'b0;
      if (!io_bus.en) begin
        r_state      <= ST_IDLE;
        r_settle_cnt <= 4'd0;
        r_dwell_cnt  <= {DWELL_W{1'b0}};
        r_out_valid  <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any_req) begin
              r_sel          <= w_pick;
              r_last_served  <= w_pick;
              r_switch_pulse <= (w_pick != r_sel);
              r_busy         <= 1'b1;
              if (SETTLE_CYC == 0) begin
                r_state     <= ST_DWELL;
                r_dwell_cnt <= w_pick_dwell;
                r_out_valid <= 1'b1;
              end else begin
                r_state      <= ST_SETTLE;
                r_settle_cnt <= 4'd0;
                r_out_valid  <= 1'b0;
              end
            end else begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          ST_SETTLE: begin
            // Dwell length is captured from the granted channel on the final settle cycle.
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state      <= ST_DWELL;
              r_settle_cnt <= 4'd0;
              r_dwell_cnt  <= w_cur_dwell;
              r_out_valid  <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + 4'd1;
            end
          end
          ST_DWELL: begin
            if (r_dwell_cnt == DWELL_ONE) begin
              if (w_other_req) begin
                r_sel          <= ~r_sel;
                r_last_served  <= ~r_sel;
                r_switch_pulse <= 1'b1;
                if (SETTLE_CYC == 0) begin
                  r_dwell_cnt <= w_other_dwell;
                end else begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= 4'd0;
                  r_out_valid  <= 1'b0;
                end
              end else if (w_cur_req) begin
                r_dwell_cnt <= w_cur_dwell;
              end else begin
                r_state     <= ST_IDLE;
                r_dwell_cnt <= {DWELL_W{1'b0}};
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
              end
            end else begin
              r_dwell_cnt <= r_dwell_cnt - DWELL_ONE;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_dwell_cnt  <= {DWELL_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.sel          = r_sel;
  assign io_bus.out_valid    = r_out_valid;
  assign io_bus.switch_pulse = r_switch_pulse;
  assign io_bus.busy         = r_busy;

endmodule

// File: doc/tdm_sel_ctrl.md
Name: tdm_sel_ctrl

Overview:
- Clocked time-division controller that generates the `sel` line for the transmission-gate 2x1 mux.
- Arbitrates between two requesting channels and holds each selection for a programmable dwell time.
- Inserts settle cycles after every switch so the TG path can stabilise.
- Flags when the mux output is valid for the downstream sampler.

Parameters:
- DWELL_W, 8: width of the dwell-count inputs and the internal dwell counter.
- SETTLE_CYC, 2: cycles `out_valid` stays low after a selection is made. 0 means no settle phase; legal range is 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  controller enable; low forces IDLE.
- req_1  input  1  channel 1 (mux in_1) requests the output.
- req_2  input  1  channel 2 (mux in_2) requests the output.
- dwell_1  input  DWELL_W  dwell cycles for channel 1; 0 is treated as 1.
- dwell_2  input  DWELL_W  dwell cycles for channel 2; 0 is treated as 1.
- sel  output  1  mux select: 0 passes in_1, 1 passes in_2.
- out_valid  output  1  high while the mux output is settled and owned by the granted channel.
- switch_pulse  output  1  one-cycle pulse in the first cycle a new `sel` value is driven.
- busy  output  1  high in the SETTLE and DWELL states.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: sel=0, out_valid=0, switch_pulse=0, busy=0.
  - Internal: state=IDLE, settle_cnt=0, dwell_cnt=0, last_served=channel 2, so channel 1 wins the first tie.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETTLE, DWELL.
- Channel pick, used in IDLE and at dwell end:
  - Only one req high: that channel.
  - Both high: the channel not equal to last_served (round robin).
- IDLE:
  - out_valid=0; sel holds its last value.
  - If en & (req_1|req_2): pick a channel, drive sel, set last_served.
  - Next state is SETTLE, or DWELL if SETTLE_CYC=0.
  - The settle phase applies even when the picked channel equals the current sel.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles, counted from the first cycle with the new sel; out_valid=0.
  - On exit, load dwell_cnt with dwell_x of the granted channel, sampled on the last SETTLE cycle (0→1).
- DWELL:
  - out_valid=1 for exactly the loaded dwell count; dwell inputs changing mid-dwell have no effect.
  - On the last dwell cycle, evaluated on the same-cycle reqs:
    - Other channel requesting: toggle sel, set last_served, switch_pulse=1 next cycle, go to SETTLE (or DWELL if SETTLE_CYC=0).
    - Else current channel still requesting: reload dwell with no settle; out_valid stays high continuously.
    - Else: go to IDLE with out_valid=0; sel holds.
- switch_pulse:
  - High for exactly one cycle whenever the registered sel value changes.
  - Never high when sel is re-driven to the same value.
- en deasserted in any state:
  - Next cycle goes to IDLE with out_valid=0, busy=0; sel holds; counters clear.
  - A dwell in progress is abandoned.
- Request timing: a req dropping mid-dwell does not shorten the dwell; reqs are only sampled in IDLE and on the last dwell cycle.
- Reset mid-operation: asynchronous return to reset values immediately, regardless of state.
- Latency: en & req in cycle T gives new sel at T+1, and first out_valid at T+1+SETTLE_CYC.

Test Plan:
- Reset check: rst high with random inputs → sel=0, out_valid=0, switch_pulse=0, busy=0 immediately, before any clk edge.
- Single channel, SETTLE_CYC=2, dwell_2=5, req_2 held for one grant → sel=1 at T+1 with switch_pulse=1 for 1 cycle; out_valid low 2 cycles, then high exactly 5 cycles; then IDLE with sel=1 held.
- Round robin: req_1=req_2=1 continuously, dwell_1=3, dwell_2=4, SETTLE_CYC=2 → sel pattern 0,1,0,1…; each grant is 2 cycles invalid plus 3 or 4 valid; one switch_pulse per toggle.
- Back-to-back same channel: req_1 held, dwell_1=0 → out_valid high every cycle after the first settle (dwell treated as 1, no re-settle); switch_pulse never fires after reset.
- Abort: en dropped on the 2nd cycle of a dwell of 6 → next cycle out_valid=0, busy=0, sel unchanged; re-enable gives a fresh settle of 2.
- Async reset mid-DWELL with sel=1 → sel=0, out_valid=0 without a clock edge; after release with req_1=req_2=1, channel 1 is granted first.
